change_dispenser: RTL

- Downstream of the vending controller. Takes a refund request carrying the remaining credit in cents and pays it out as dollar and quarter coins through a coin hopper.
- Uses a greedy, largest-coin-first algorithm with a per-coin eject/ack handshake.
- Tracks its own coin inventory and reports any amount it could not pay.
- Times out and enters a fault state if the hopper stops acknowledging.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/change_dispenser_if.sv | 50 +++++
 rtl/coin_inventory.sv | 31 +++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions used by the change dispenser and the vending
// controller: FSM state encoding, coin selector and coin values in cents.
package vend_pkg;

  localparam int QUARTER_VAL = 25;
  localparam int DOLLAR_VAL  = 100;

  // Explicit encodings so legacy code can keep using raw 3-bit constants.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_QUARTER = 2'd1,
    COIN_DOLLAR  = 2'd2
  } coin_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending controller / coin hopper and the change dispenser.
//   master: drives the refund request, inventory loads and hopper_ack.
//   slave : the dispenser; drives eject commands, status and inventory counts.
// With CHANGE_DISPENSER_STATS_EN defined the bus also carries total_paid and
// fault_count.
interface change_dispenser_if #(
  parameter int AMT_W = 12,
  parameter int CNT_W = 8
) ();
  logic             refund_req;
  logic [AMT_W-1:0] refund_amt;
  logic             load_quarters;
  logic             load_dollars;
  logic [CNT_W-1:0] load_cnt;
  logic             hopper_ack;
  logic             eject_quarter;
  logic             eject_dollar;
  logic             busy;
  logic             refund_done;
  logic [AMT_W-1:0] refund_short;
  logic             hopper_fault;
  logic [CNT_W-1:0] quarters_left;
  logic [CNT_W-1:0] dollars_left;
`ifdef CHANGE_DISPENSER_STATS_EN
  logic [AMT_W+7:0] total_paid;
  logic [7:0]       fault_count;

  modport master (
    output refund_req, refund_amt, load_quarters, load_dollars, load_cnt, hopper_ack,
    input  eject_quarter, eject_dollar, busy, refund_done, refund_short, hopper_fault,
           quarters_left, dollars_left, total_paid, fault_count
  );
  modport slave (
    input  refund_req, refund_amt, load_quarters, load_dollars, load_cnt, hopper_ack,
    output eject_quarter, eject_dollar, busy, refund_done, refund_short, hopper_fault,
           quarters_left, dollars_left, total_paid, fault_count
  );
`else
  modport master (
    output refund_req, refund_amt, load_quarters, load_dollars, load_cnt, hopper_ack,
    input  eject_quarter, eject_dollar, busy, refund_done, refund_short, hopper_fault,
           quarters_left, dollars_left
  );
  modport slave (
    input  refund_req, refund_amt, load_quarters, load_dollars, load_cnt, hopper_ack,
    output eject_quarter, eject_dollar, busy, refund_done, refund_short, hopper_fault,
           quarters_left, dollars_left
  );
`endif
endinterface

// File: rtl/coin_inventory.sv
// One coin-type inventory counter.
//   clk, reset : clock, synchronous active-high reset (count goes to full)
//   load       : add load_cnt, saturating at all-ones
//   load_cnt   : number of coins to add
//   dec        : one coin was released by the hopper
//   count      : current number of coins
module coin_inventory #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0] sum;

  // Extra carry bit tells us the add overflowed and must clamp.
  assign sum = {1'b0, count} + {1'b0, load_cnt};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset)     count <= '1;
    else if (load) count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    else if (dec)  count <= count - 1'b1;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a refund greedily as dollar then quarter coins via a
// coin hopper with a per-coin eject/ack handshake, tracks coin inventory and
// reports any unpaid remainder. Faults (sticky) if the hopper stops acking.
//   clk, reset : clock, synchronous active-high reset
//   bus        : change_dispenser_if slave (request, loads, hopper handshake,
//                status and inventory counts)
// Optional: CHANGE_DISPENSER_STATS_EN adds total_paid and fault_count.
module change_dispenser #(
  parameter int AMT_W       = 12,
  parameter int CNT_W       = 8,
  parameter int QUARTER_VAL = vend_pkg::QUARTER_VAL,
  parameter int DOLLAR_VAL  = vend_pkg::DOLLAR_VAL,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus
);
  import vend_pkg::*;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_SELECT   = ST_SELECT;
  localparam logic [2:0] S_EJECT    = ST_EJECT;
  localparam logic [2:0] S_WAIT_ACK = ST_WAIT_ACK;
  localparam logic [2:0] S_DONE     = ST_DONE;
  localparam logic [2:0] S_FAULT    = ST_FAULT;
  localparam int         TMR_W      = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]       state;
  coin_e            coin;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] short_amt;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] quarters;
  logic [CNT_W-1:0] dollars;
  logic [AMT_W-1:0] coin_amt;
  logic             in_idle;
  logic             ack_ok;
  logic             dollar_ok;
  logic             quarter_ok;
  logic             timeout;

  assign in_idle    = (state == S_IDLE);
  assign ack_ok     = (state == S_WAIT_ACK) && bus.hopper_ack;
  assign timeout    = (state == S_WAIT_ACK) && !bus.hopper_ack &&
                      (timer == TMR_W'(ACK_TIMEOUT - 1));
  assign coin_amt   = (coin == COIN_DOLLAR) ? AMT_W'(DOLLAR_VAL) : AMT_W'(QUARTER_VAL);
  // SELECT only picks a coin that fits in rem and is in stock, so the
  // subtract and decrement on ack can never wrap.
  assign dollar_ok  = (rem >= AMT_W'(DOLLAR_VAL))  && (dollars  != '0);
  assign quarter_ok = (rem >= AMT_W'(QUARTER_VAL)) && (quarters != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      coin      <= COIN_NONE;
      rem       <= '0;
      short_amt <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.refund_req) begin
            rem   <= bus.refund_amt;
            state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (dollar_ok) begin
            coin  <= COIN_DOLLAR;
            state <= S_EJECT;
          end else if (quarter_ok) begin
            coin  <= COIN_QUARTER;
            state <= S_EJECT;
          end else begin
            // Capture on entry so refund_short is valid during the done pulse.
            short_amt <= rem;
            state     <= S_DONE;
          end
        end
        S_EJECT: begin
          timer <= '0;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (bus.hopper_ack) begin
            rem   <= rem - coin_amt;
            state <= S_SELECT;
          end else if (timeout) begin
            short_amt <= rem;
            state     <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Loads are accepted only in IDLE; a load alongside refund_req lands on the
  // same edge as the request, so SELECT already sees the new count.
  coin_inventory #(.CNT_W(CNT_W)) u_quarters (
    .clk      (clk),
    .reset    (reset),
    .load     (bus.load_quarters && in_idle),
    .load_cnt (bus.load_cnt),
    .dec      (ack_ok && (coin == COIN_QUARTER)),
    .count    (quarters)
  );

  coin_inventory #(.CNT_W(CNT_W)) u_dollars (
    .clk      (clk),
    .reset    (reset),
    .load     (bus.load_dollars && in_idle),
    .load_cnt (bus.load_cnt),
    .dec      (ack_ok && (coin == COIN_DOLLAR)),
    .count    (dollars)
  );

  // Outputs decode straight from registered state; coin holds one value, so
  // the two eject lines are mutually exclusive.
  assign bus.eject_quarter = (state == S_EJECT) && (coin == COIN_QUARTER);
  assign bus.eject_dollar  = (state == S_EJECT) && (coin == COIN_DOLLAR);
  assign bus.busy          = !in_idle;
  assign bus.refund_done   = (state == S_DONE);
  assign bus.refund_short  = short_amt;
  assign bus.hopper_fault  = (state == S_FAULT);
  assign bus.quarters_left = quarters;
  assign bus.dollars_left  = dollars;

`ifdef CHANGE_DISPENSER_STATS_EN
  logic [AMT_W+7:0] total_paid;
  logic [7:0]       fault_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      total_paid  <= '0;
      fault_count <= '0;
    end else begin
      if (ack_ok)                          total_paid  <= total_paid + (AMT_W+8)'(coin_amt);
      if (timeout && fault_count != 8'hFF) fault_count <= fault_count + 1'b1;
    end
  end

  assign bus.total_paid  = total_paid;
  assign bus.fault_count = fault_count;
`endif

endmodule
